// File: rtl/hiscore_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hiscore_pkg
// Purpose  : Shared types and constants for the high-score upload block:
//            FSM state encoding, read-data source select, the HPS-visible
//            read latency and the fill byte returned for unbacked addresses.
// Macro    : HISCORE_CHECKSUM_EN adds the SCAN state to the state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package hiscore_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PAUSE = 3'd1,
`ifdef HISCORE_CHECKSUM_EN
        SCAN  = 3'd2,
`endif
        READY = 3'd3,
        FETCH = 3'd4,
        LATCH = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Where the byte captured in LATCH comes from.
    typedef enum logic [1:0] {
        SRC_RAM  = 2'd0,
        SRC_FILL = 2'd1,
        SRC_SUM  = 2'd2
    } source_t;

    // Cycles from the ioctl_rd strobe until ioctl_wait falls with data valid.
    localparam int unsigned READ_LATENCY = 3;

    // Byte returned for addresses that are not backed by core RAM.
    localparam logic [7:0] FILL_BYTE = 8'h00;

endpackage
`default_nettype wire

// File: rtl/hiscore_upload_if.sv
`default_nettype none
// ============================================================================
// Module   : hiscore_upload_if
// Purpose  : Bundles the HPS ioctl upload channel, the core pause handshake
//            and the core RAM read port.
// Modports : slave  - the upload block (drives din/wait/pause_req/ram_addr/
//                     timeout_flag)
//            master - the environment (HPS, core CPU and core RAM)
// Revision : 1.0 - initial release
// ============================================================================
interface hiscore_upload_if;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        pause_req;
    logic        pause_ack;
    logic [10:0] ram_addr;
    logic [7:0]  ram_q;
    logic        timeout_flag;

    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_addr, pause_ack, ram_q,
        output ioctl_din, ioctl_wait, pause_req, ram_addr, timeout_flag
    );

    modport master (
        output ioctl_upload, ioctl_rd, ioctl_addr, pause_ack, ram_q,
        input  ioctl_din, ioctl_wait, pause_req, ram_addr, timeout_flag
    );
endinterface
`default_nettype wire

// File: rtl/hiscore_timeout.sv
`default_nettype none
// ============================================================================
// Module   : hiscore_timeout
// Purpose  : Loadable down-counter that bounds the wait for pause_ack.
//            expire_o is high whenever the count has reached zero.
// Ports    : clk_sys  - clock
//            reset_n  - asynchronous active-low reset (count -> 0)
//            load_i   - load LOAD_VALUE
//            en_i     - decrement (saturates at zero)
//            expire_o - count is zero
// Revision : 1.0 - initial release
// ============================================================================
module hiscore_timeout #(
    parameter int unsigned LOAD_VALUE = 1022
) (
    input  wire logic clk_sys,
    input  wire logic reset_n,
    input  wire logic load_i,
    input  wire logic en_i,
    output logic      expire_o
);

    localparam int unsigned CNT_W = (LOAD_VALUE > 0) ? $clog2(LOAD_VALUE + 1) : 1;

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= CNT_W'(LOAD_VALUE);
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expire_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/hiscore_upload.sv
`default_nettype none
// ============================================================================
// Module   : hiscore_upload
// Purpose  : Serves a window of core RAM to the HPS during an ioctl upload
//            session. The core CPU is paused for the whole session; each
//            ioctl_rd is answered with a fixed 3-cycle latency while
//            ioctl_wait stalls the HPS.
// Ports    : clk_sys - clock (posedge)
//            reset_n - asynchronous active-low reset
//            bus     - hiscore_upload_if.slave (ioctl, pause and RAM signals)
// Macro    : HISCORE_CHECKSUM_EN - after the pause, scan the whole window and
//            serve the inverted 8-bit sum at address DATA_SIZE.
// Revision : 1.0 - initial release
// ============================================================================
module hiscore_upload
    import hiscore_pkg::*;
#(
    parameter int unsigned DATA_SIZE     = 256,
    parameter logic [10:0] RAM_BASE      = 11'h000,
    parameter int unsigned PAUSE_TIMEOUT = 1023
) (
    input  wire logic       clk_sys,
    input  wire logic       reset_n,
    hiscore_upload_if.slave bus
);

    // The counter is loaded on PAUSE entry and reaches zero in the last of
    // PAUSE_TIMEOUT PAUSE cycles, so the exit lands exactly on that count.
    localparam int unsigned TIMEOUT_LOAD = (PAUSE_TIMEOUT > 0) ? PAUSE_TIMEOUT - 1 : 0;

    state_t      state_q;
    source_t     src_q;
    logic        upload_prev_q;
    logic [7:0]  din_q;
    logic        wait_q;
    logic        pause_q;
    logic [10:0] ram_addr_q;
    logic        flag_q;
`ifdef HISCORE_CHECKSUM_EN
    logic [7:0]  sum_q;
    logic [11:0] scan_cnt_q;
`endif

    logic        upload_rise;
    logic        in_range;
    logic [10:0] rd_ram_addr;
    logic        tmo_expire;

    assign upload_rise = bus.ioctl_upload && !upload_prev_q;
    assign in_range    = (bus.ioctl_addr < 25'(DATA_SIZE));
    assign rd_ram_addr = RAM_BASE + bus.ioctl_addr[10:0];

    hiscore_timeout #(
        .LOAD_VALUE (TIMEOUT_LOAD)
    ) u_timeout (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .load_i   ((state_q == IDLE) && upload_rise),
        .en_i     (state_q == PAUSE),
        .expire_o (tmo_expire)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            src_q         <= SRC_FILL;
            // Reset as "already high" so an upload level that is still
            // asserted after reset is not seen as a new session.
            upload_prev_q <= 1'b1;
            din_q         <= 8'h00;
            wait_q        <= 1'b0;
            pause_q       <= 1'b0;
            ram_addr_q    <= 11'h000;
            flag_q        <= 1'b0;
`ifdef HISCORE_CHECKSUM_EN
            sum_q         <= 8'h00;
            scan_cnt_q    <= 12'd0;
`endif
        end else begin
            upload_prev_q <= bus.ioctl_upload;
            if (upload_rise) begin
                flag_q <= 1'b0;
            end

            if ((state_q != IDLE) && (state_q != DONE) && !bus.ioctl_upload) begin
                // Session ended by the HPS: drop everything, abandon any fetch.
                state_q <= DONE;
                pause_q <= 1'b0;
                wait_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (upload_rise) begin
                            state_q <= PAUSE;
                            pause_q <= 1'b1;
                            wait_q  <= 1'b1;
                        end
                    end

                    PAUSE: begin
                        if (bus.pause_ack || tmo_expire) begin
                            if (!bus.pause_ack) begin
                                flag_q <= 1'b1;
                            end
`ifdef HISCORE_CHECKSUM_EN
                            state_q    <= SCAN;
                            scan_cnt_q <= 12'd0;
                            sum_q      <= 8'h00;
                            ram_addr_q <= RAM_BASE;
`else
                            state_q    <= READY;
                            wait_q     <= 1'b0;
`endif
                        end
                    end

`ifdef HISCORE_CHECKSUM_EN
                    // scan_cnt_q = c: address c is on ram_addr, ram_q holds
                    // byte c-1. Bytes land on c = 1..DATA_SIZE; the final
                    // count DATA_SIZE+1 closes the scan.
                    SCAN: begin
                        if ((scan_cnt_q >= 12'd1) && (scan_cnt_q <= 12'(DATA_SIZE))) begin
                            sum_q <= sum_q + bus.ram_q;
                        end
                        if ((scan_cnt_q + 12'd1) < 12'(DATA_SIZE)) begin
                            ram_addr_q <= RAM_BASE + scan_cnt_q[10:0] + 11'd1;
                        end
                        if (scan_cnt_q == 12'(DATA_SIZE + 1)) begin
                            state_q <= READY;
                            wait_q  <= 1'b0;
                        end else begin
                            scan_cnt_q <= scan_cnt_q + 12'd1;
                        end
                    end
`endif

                    READY: begin
                        if (bus.ioctl_rd) begin
                            state_q <= FETCH;
                            wait_q  <= 1'b1;
                            if (in_range) begin
                                ram_addr_q <= rd_ram_addr;
                                src_q      <= SRC_RAM;
`ifdef HISCORE_CHECKSUM_EN
                            end else if (bus.ioctl_addr == 25'(DATA_SIZE)) begin
                                src_q      <= SRC_SUM;
`endif
                            end else begin
                                src_q      <= SRC_FILL;
                            end
                        end
                    end

                    // RAM answers during this cycle; nothing to do but wait.
                    FETCH: begin
                        state_q <= LATCH;
                    end

                    LATCH: begin
                        case (src_q)
                            SRC_RAM: din_q <= bus.ram_q;
`ifdef HISCORE_CHECKSUM_EN
                            SRC_SUM: din_q <= ~sum_q;
`endif
                            default: din_q <= FILL_BYTE;
                        endcase
                        wait_q  <= 1'b0;
                        state_q <= READY;
                    end

                    DONE: begin
                        state_q <= IDLE;
                        pause_q <= 1'b0;
                        wait_q  <= 1'b0;
                    end

                    default: begin
                        state_q <= IDLE;
                        pause_q <= 1'b0;
                        wait_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ioctl_din    = din_q;
    assign bus.ioctl_wait   = wait_q;
    assign bus.pause_req    = pause_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.timeout_flag = flag_q;

endmodule
`default_nettype wire
